qif_spike_monitor: RTL and testbench
====================================

Name: qif_spike_monitor

Overview:
- Downstream consumer of the QIF neuron's 8-bit signed membrane output.
- Detects spike events from the voltage trace and emits a registered one-cycle spike pulse.
- Measures the inter-spike interval (ISI) and the spike count per fixed window.
- The window count is delivered over a valid/ready handshake to the readout/IO stage.

Parameters:
- VPEAK, 50, signed 8-bit upward threshold crossing that marks a spike.
- DROP_TH, 40, minimum signed sample-to-sample fall (prev - curr) that marks a spike (post-fire reset).
- WIN_CYCLES, 256, window length in clock cycles, ≥ 2.
- CNT_W, 8, width of the spike-count output, saturating.
- ISI_W, 12, width of the ISI output, saturating.

Ports:
- clk  in  1  Single system clock; all state updates on the rising edge.
- rst_n  in  1  Reset. Asynchronous and active-high: 1 = reset, despite the name.
- v_in  in  8  Signed membrane voltage from the neuron, sampled every cycle when en=1.
- en  in  1  Sample enable. When 0, all counters, v_prev and the FSM hold.
- spike_o  out  1  One-cycle pulse, one cycle after the detecting sample.
- isi_o  out  ISI_W  Last measured ISI in cycles. Held until the next measurement.
- isi_valid_o  out  1  One-cycle pulse when isi_o updates.
- rate_o  out  CNT_W  Spike count of the last completed window.
- rate_valid_o  out  1  rate_o holds unconsumed data.
- rate_ready_i  in  1  Consumer accepts rate_o when rate_valid_o && rate_ready_i.
- overrun_o  out  1  Sticky flag: a window result overwrote an unconsumed result.

Behaviour:
- Reset values:
  - Outputs spike_o, isi_o, isi_valid_o, rate_o, rate_valid_o, overrun_o all 0.
  - Internal: v_prev = -20; window counter = 0; window spike count = 0; since-spike counter = 0; FSM = NO_REF.
- Reset mid-operation discards the pending rate result and any partial window. No handshake completes in the reset cycle.
- Spike detection, per enabled cycle, using signed arithmetic:
  - rise = (v_prev < VPEAK) && (v_in >= VPEAK)
  - drop = (v_prev - v_in) >= DROP_TH, computed at 9-bit signed width so there is no wrap.
  - spike = rise || drop. Both true in the same cycle counts as one spike.
  - v_prev <= v_in every enabled cycle.
- spike_o <= spike (registered). Latency is exactly 1 cycle. spike_o is 0 on cycles with en=0.
- ISI FSM:
  - NO_REF:
    - On a spike: since-spike counter <= 1; go to TRACK.
    - No ISI output from NO_REF.
  - TRACK:
    - Non-spike enabled cycle: since-spike counter increments, saturating at 2^ISI_W-1.
    - Spike: isi_o <= since-spike counter; isi_valid_o pulses next cycle; counter <= 1.
  - Spikes on consecutive enabled cycles give ISI = 1.
- Window:
  - The window counter counts enabled cycles 0..WIN_CYCLES-1.
  - The window spike count increments on each spike, saturating at 2^CNT_W-1.
  - On the enabled cycle where window counter == WIN_CYCLES-1 (the final-cycle spike is included):
    - rate_o <= final count; rate_valid_o <= 1.
    - Window counter and count reset to 0, or to 1 if... no: count resets to 0 and the window counter to 0.
    - If rate_valid_o=1 and !rate_ready_i in that same cycle: the new result overwrites and overrun_o <= 1 (sticky until reset).
    - If handshake and new result coincide: valid stays 1 with the new data, and no overrun.
- Handshake:
  - rate_valid_o clears the cycle after rate_valid_o && rate_ready_i, unless a new result loads in that cycle.
  - rate_o is stable while valid and not accepted.
  - rate_ready_i is ignored when valid=0.

Decomposition:
- Shared package qif_pkg holds:
  - the voltage type (signed 8-bit);
  - constants V_PEAK=50 and V_RESET=-20, used by both the neuron and this monitor;
  - default widths CNT_W and ISI_W.
- One natural sub-module: qif_spike_detect, holding v_prev, the rise/drop compare and the registered spike pulse.
- The ISI FSM, window counter and handshake register stay in the top module.

Test Plan:
- Reset and first sample: hold rst_n=1, release, drive v_in=-20 then 30 -> spike_o never asserts, and all outputs read 0 after reset.
- Rise crossing: v_in sequence 10,40,50,55 -> spike_o=1 exactly once, one cycle after the 50 sample. A later 49→60 crossing pulses again.
- Drop detection: v_in 45 then 0 (fall 45) -> spike. 45 then 10 (fall 35) -> no spike. -128 after 127 -> spike, with no wrap error.
- ISI: spikes on enabled cycles 10, 17, 18 -> first spike gives no isi_valid; then isi_o=7, then isi_o=1, each with a single-cycle isi_valid_o. With en=0 for 5 cycles between spikes, the ISI excludes those cycles.
- Window/handshake: WIN_CYCLES=16, 3 spikes in window 1, rate_ready_i=1 -> rate_o=3 with valid for 1 cycle. Then hold ready=0 across 2 windows (5 then 2 spikes) -> rate_o=2, overrun_o=1 sticky.
- Saturation: CNT_W=2 with 6 spikes in one window -> rate_o=3. ISI_W=4 with 40 idle cycles -> isi_o=15.

Source files
------------

// File: rtl/qif_pkg.sv
// Types and constants shared by the QIF neuron and its downstream spike monitor.
package qif_pkg;

    localparam int V_W = 8;
    typedef logic signed [V_W-1:0] volt_t;

    localparam volt_t V_PEAK  = 8'sd50;
    localparam volt_t V_RESET = -8'sd20;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_ISI_W = 12;

    typedef enum logic {
        NO_REF,
        TRACK
    } isi_state_e;

endpackage

// File: rtl/qif_spike_detect.sv
// Spike detector: flags an upward crossing of VPEAK or a steep post-fire drop,
// and registers the result as a one-cycle pulse.
module qif_spike_detect
    import qif_pkg::*;
#(
    parameter volt_t VPEAK   = V_PEAK,
    parameter int    DROP_TH = 40
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  volt_t v_i,
    output logic  spike_det_o,
    output logic  spike_o
);

    localparam logic signed [V_W:0] DROP_TH_X = (V_W+1)'(DROP_TH);

    volt_t             v_prev_q, v_prev_d;
    logic              spike_q, spike_d;
    logic signed [V_W:0] fall;
    logic              rise, drop;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        v_prev_d = v_prev_q;
        // Sign-extend both operands so a 127 -> -128 step reads as +255, not a wrapped -1.
        fall = {v_prev_q[V_W-1], v_prev_q} - {v_i[V_W-1], v_i};
        rise = (v_prev_q < VPEAK) && (v_i >= VPEAK);
        drop = (fall >= DROP_TH_X);
        spike_det_o = en_i && (rise || drop);
        spike_d     = spike_det_o;
        if (en_i) begin
            v_prev_d = v_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_prev_q <= V_RESET;
            spike_q  <= 1'b0;
        end else begin
            v_prev_q <= v_prev_d;
            spike_q  <= spike_d;
        end
    end

    assign spike_o = spike_q;

endmodule

// File: rtl/qif_spike_monitor.sv
// Spike monitor: spike pulse, inter-spike interval and per-window spike rate
// delivered over a valid/ready handshake with a sticky overrun flag.
module qif_spike_monitor
    import qif_pkg::*;
#(
    parameter volt_t VPEAK      = V_PEAK,
    parameter int    DROP_TH    = 40,
    parameter int    WIN_CYCLES = 256,
    parameter int    CNT_W      = DEF_CNT_W,
    parameter int    ISI_W      = DEF_ISI_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  volt_t            v_in,
    input  logic             en,
    output logic             spike_o,
    output logic [ISI_W-1:0] isi_o,
    output logic             isi_valid_o,
    output logic [CNT_W-1:0] rate_o,
    output logic             rate_valid_o,
    input  logic             rate_ready_i,
    output logic             overrun_o
);

    localparam int               WIN_W    = $clog2(WIN_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    // The reset pin keeps its historical name but is active-high.
    logic rst;
    assign rst = rst_n;

    logic spike;

    qif_spike_detect #(
        .VPEAK   (VPEAK),
        .DROP_TH (DROP_TH)
    ) u_detect (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .v_i         (v_in),
        .spike_det_o (spike),
        .spike_o     (spike_o)
    );

    isi_state_e       state_q, state_d;
    logic [ISI_W-1:0] since_q, since_d;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic             isi_valid_q, isi_valid_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             rate_valid_q, rate_valid_d;
    logic             overrun_q, overrun_d;
    logic             load, accept;

    always_comb begin
        state_d      = state_q;
        since_d      = since_q;
        isi_d        = isi_q;
        isi_valid_d  = 1'b0;
        win_d        = win_q;
        cnt_d        = cnt_q;
        rate_d       = rate_q;
        rate_valid_d = rate_valid_q;
        overrun_d    = overrun_q;

        cnt_inc = (spike && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        load    = en && (win_q == WIN_LAST);
        accept  = rate_valid_q && rate_ready_i;

        if (en) begin
            unique case (state_q)
                NO_REF: begin
                    if (spike) begin
                        since_d = ISI_W'(1);
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (spike) begin
                        isi_d       = since_q;
                        isi_valid_d = 1'b1;
                        since_d     = ISI_W'(1);
                    end else if (since_q != '1) begin
                        since_d = since_q + ISI_W'(1);
                    end
                end
                default: state_d = NO_REF;
            endcase

            if (load) begin
                win_d = '0;
                cnt_d = '0;
            end else begin
                win_d = win_q + WIN_W'(1);
                cnt_d = cnt_inc;
            end
        end

        // A new window result wins over a same-cycle acceptance; only an unaccepted result counts as overrun.
        if (load) begin
            rate_d       = cnt_inc;
            rate_valid_d = 1'b1;
            if (rate_valid_q && !rate_ready_i) begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            rate_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= NO_REF;
            since_q      <= '0;
            isi_q        <= '0;
            isi_valid_q  <= 1'b0;
            win_q        <= '0;
            cnt_q        <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            since_q      <= since_d;
            isi_q        <= isi_d;
            isi_valid_q  <= isi_valid_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign isi_o        = isi_q;
    assign isi_valid_o  = isi_valid_q;
    assign rate_o       = rate_q;
    assign rate_valid_o = rate_valid_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_qif_spike_monitor.sv
// Directed bench for qif_spike_monitor: a default-width instance and a narrow
// instance (CNT_W=2, ISI_W=4) share one stimulus stream, both with 16-cycle windows.
module tb_qif_spike_monitor;
    import qif_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  en;
    logic  rdy;
    volt_t v_in;

    logic        spike_a, isiv_a, rv_a, ov_a;
    logic [11:0] isi_a;
    logic [7:0]  rate_a;
    logic        spike_b, isiv_b, rv_b, ov_b;
    logic [3:0]  isi_b;
    logic [1:0]  rate_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    qif_spike_monitor #(
        .WIN_CYCLES (16),
        .CNT_W      (8),
        .ISI_W      (12)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .v_in         (v_in),
        .en           (en),
        .spike_o      (spike_a),
        .isi_o        (isi_a),
        .isi_valid_o  (isiv_a),
        .rate_o       (rate_a),
        .rate_valid_o (rv_a),
        .rate_ready_i (rdy),
        .overrun_o    (ov_a)
    );

    qif_spike_monitor #(
        .WIN_CYCLES (16),
        .CNT_W      (2),
        .ISI_W      (4)
    ) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .v_in         (v_in),
        .en           (en),
        .spike_o      (spike_b),
        .isi_o        (isi_b),
        .isi_valid_o  (isiv_b),
        .rate_o       (rate_b),
        .rate_valid_o (rv_b),
        .rate_ready_i (rdy),
        .overrun_o    (ov_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply one sample, then look at the registered outputs just after the edge.
    task automatic tick(input volt_t v, input logic e);
        v_in = v;
        en   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b1;
        en    = 1'b0;
        rdy   = 1'b0;
        v_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst spike_o", 32'(spike_a), 0);
        check("rst isi_o", 32'(isi_a), 0);
        check("rst isi_valid_o", 32'(isiv_a), 0);
        check("rst rate_o", 32'(rate_a), 0);
        check("rst rate_valid_o", 32'(rv_a), 0);
        check("rst overrun_o", 32'(ov_a), 0);
        rst_n = 1'b0;
    endtask

    // One 16-cycle window with n spikes on the last odd cycles (final cycle included).
    task automatic run_window(input int n, input logic r0, input logic rm, input logic rl,
                              output logic fv, output logic [7:0] fr);
        fv = 1'b0;
        fr = '0;
        for (int c = 0; c < 16; c++) begin
            rdy = (c == 0) ? r0 : ((c == 15) ? rl : rm);
            tick(((c % 2 == 1) && (c / 2 >= 8 - n)) ? 8'sd50 : 8'sd20, 1'b1);
            if (c == 0) begin
                fv = rv_a;
                fr = rate_a;
            end
        end
        rdy = 1'b0;
    endtask

    typedef struct {
        volt_t v;
        logic  e;
        logic  exp_spike;
    } vec_t;

    vec_t        vecs[17];
    logic        fv;
    logic [7:0]  fr;

    initial begin
        vecs[0]  = '{-8'sd20,   1'b1, 1'b0};
        vecs[1]  = '{8'sd30,    1'b1, 1'b0};
        vecs[2]  = '{8'sd10,    1'b1, 1'b0};
        vecs[3]  = '{8'sd40,    1'b1, 1'b0};
        vecs[4]  = '{8'sd50,    1'b1, 1'b1};
        vecs[5]  = '{8'sd55,    1'b1, 1'b0};
        vecs[6]  = '{8'sd49,    1'b1, 1'b0};
        vecs[7]  = '{8'sd60,    1'b1, 1'b1};
        vecs[8]  = '{8'sd45,    1'b1, 1'b0};
        vecs[9]  = '{8'sd0,     1'b1, 1'b1};
        vecs[10] = '{8'sd45,    1'b1, 1'b0};
        vecs[11] = '{8'sd10,    1'b1, 1'b0};
        vecs[12] = '{8'sd127,   1'b1, 1'b1};
        vecs[13] = '{-8'sd128,  1'b1, 1'b1};
        vecs[14] = '{8'sd100,   1'b0, 1'b0};
        vecs[15] = '{8'sd60,    1'b0, 1'b0};
        vecs[16] = '{8'sd55,    1'b1, 1'b1};

        // Reset state, then spike detection vectors.
        reset_dut();
        foreach (vecs[i]) begin
            tick(vecs[i].v, vecs[i].e);
            check($sformatf("spike vec%0d", i), 32'(spike_a), 32'(vecs[i].exp_spike));
            check($sformatf("spike_b vec%0d", i), 32'(spike_b), 32'(vecs[i].exp_spike));
        end

        // ISI: spikes on enabled cycles 10, 17, 18.
        reset_dut();
        for (int c = 1; c <= 18; c++) begin
            tick((c == 10 || c == 17) ? 8'sd50 : ((c == 18) ? 8'sd0 : 8'sd20), 1'b1);
            check($sformatf("isi_valid c%0d", c), 32'(isiv_a), 32'(c == 17 || c == 18));
            if (c == 10) check("first spike", 32'(spike_a), 1);
            if (c == 17) check("isi 7", 32'(isi_a), 7);
            if (c == 18) check("isi 1", 32'(isi_a), 1);
        end
        tick(8'sd20, 1'b1);
        check("isi held", 32'(isi_a), 1);
        check("isi_valid single", 32'(isiv_a), 0);
        tick(8'sd20, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(8'sd50, 1'b0);
            check($sformatf("en0 spike k%0d", k), 32'(spike_a), 0);
            check($sformatf("en0 isi_valid k%0d", k), 32'(isiv_a), 0);
        end
        tick(8'sd20, 1'b1);
        tick(8'sd50, 1'b1);
        check("isi en gap valid", 32'(isiv_a), 1);
        check("isi en gap", 32'(isi_a), 4);

        // ISI saturation: 40 idle cycles between spikes.
        repeat (40) tick(8'sd20, 1'b1);
        tick(8'sd50, 1'b1);
        check("isi long", 32'(isi_a), 41);
        check("isi sat valid", 32'(isiv_b), 1);
        check("isi sat", 32'(isi_b), 15);

        // Window and handshake.
        reset_dut();
        run_window(3, 1'b0, 1'b1, 1'b1, fv, fr);
        check("w1 valid", 32'(rv_a), 1);
        check("w1 rate", 32'(rate_a), 3);
        check("w1 overrun", 32'(ov_a), 0);
        run_window(5, 1'b1, 1'b0, 1'b0, fv, fr);
        check("w1 valid one cycle", 32'(fv), 0);
        check("w2 valid", 32'(rv_a), 1);
        check("w2 rate", 32'(rate_a), 5);
        check("w2 overrun", 32'(ov_a), 0);
        check("w2 rate sat", 32'(rate_b), 3);
        run_window(2, 1'b0, 1'b0, 1'b0, fv, fr);
        check("w2 held valid", 32'(fv), 1);
        check("w2 held rate", 32'(fr), 5);
        check("w3 rate", 32'(rate_a), 2);
        check("w3 valid", 32'(rv_a), 1);
        check("w3 overrun", 32'(ov_a), 1);
        check("w3 overrun_b", 32'(ov_b), 1);
        check("w3 valid_b", 32'(rv_b), 1);
        run_window(1, 1'b1, 1'b0, 1'b0, fv, fr);
        check("w3 accepted", 32'(fv), 0);
        check("w4 rate", 32'(rate_a), 1);
        check("overrun sticky", 32'(ov_a), 1);

        // Reset discards the pending result; then load and accept in the same cycle.
        reset_dut();
        run_window(1, 1'b0, 1'b0, 1'b0, fv, fr);
        check("wa rate", 32'(rate_a), 1);
        run_window(6, 1'b0, 1'b0, 1'b1, fv, fr);
        check("wb valid", 32'(rv_a), 1);
        check("wb rate", 32'(rate_a), 6);
        check("wb no overrun", 32'(ov_a), 0);
        check("wb rate sat", 32'(rate_b), 3);
        rdy = 1'b1;
        tick(8'sd20, 1'b1);
        check("wb accepted", 32'(rv_a), 0);
        rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
